// File: rtl/fp_mant_addsub_pipe.sv
// -----------------------------------------------------------------------------
// fp_mant_addsub_pipe
//
// Two-stage pipelined mantissa adder/subtractor for the FP add/sub datapath.
// Takes the aligned operand mantissas (B already right-shifted, with the
// guard/round/sticky bits that fell off it) and the operand signs. It applies
// the effective operation and returns a sign/magnitude result for the
// normaliser/rounder.
//
// Stage 1 registers the widened operands, the effective operation and the
// magnitude comparison. Stage 2 performs the add or the ordered subtract
// (larger minus smaller, so the magnitude is never negative) and registers
// the result. Every output is driven straight from a flop.
//
// Optional build macro: ADDSUB_LZC_EN
//   When defined, the block also has an `lzc` output. It carries the
//   leading-zero count of {mant, GRS_out}, which is MANT_W+5 for a zero
//   result.
//
// Parameters:
//   MANT_W      stored mantissa width (23 single, 52 double, 10 half)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    operand set valid
//   in_ready    block can accept operands this cycle
//   sub         1 = A-B, 0 = A+B
//   shift_flag  B was right-shifted for alignment (B hidden bit = ~shift_flag)
//   sign_A      sign of A
//   mant_A      stored mantissa of A            [MANT_W]
//   sign_B      sign of B
//   mant_B      aligned mantissa of B           [MANT_W]
//   GRS_in      guard/round/sticky bits of B    [3]
//   out_valid   result valid
//   out_ready   downstream accepts result
//   sign        result sign
//   z_flag      result magnitude is exactly zero
//   mant        {carry, hidden, mantissa}       [MANT_W+2]
//   GRS_out     result guard/round/sticky bits  [3]
//   lzc         leading zeros of {mant,GRS_out} (ADDSUB_LZC_EN only)
// -----------------------------------------------------------------------------
module fp_mant_addsub_pipe #(
    parameter int MANT_W = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sub,
    input  logic              shift_flag,
    input  logic              sign_A,
    input  logic [MANT_W-1:0] mant_A,
    input  logic              sign_B,
    input  logic [MANT_W-1:0] mant_B,
    input  logic [2:0]        GRS_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign,
    output logic              z_flag,
    output logic [MANT_W+1:0] mant,
`ifdef ADDSUB_LZC_EN
    output logic [$clog2(MANT_W+6)-1:0] lzc,
`endif
    output logic [2:0]        GRS_out
);

    localparam int OP_W  = MANT_W + 4;  // {hidden, mantissa, GRS}
    localparam int MAG_W = MANT_W + 5;  // one extra bit for the add carry

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s2_load;   // stage 2 may take new content this cycle
    logic s1_fire;   // operands accepted into stage 1
    logic s2_fire;   // stage 1 content moves into stage 2

    // Stage 2 can load when it is empty or its result is being drained.
    assign s2_load  = ~s2_valid_q | out_ready;
    // Stage 1 can load when it is empty or its content moves to stage 2.
    assign in_ready = ~s1_valid_q | s2_load;
    assign s1_fire  = in_valid & in_ready;
    assign s2_fire  = s1_valid_q & s2_load;

    assign s1_valid_d = in_ready ? in_valid   : s1_valid_q;
    assign s2_valid_d = s2_load  ? s1_valid_q : s2_valid_q;

    // ------------------------------------------------------------------
    // Stage 1: operand construction and compare
    // ------------------------------------------------------------------
    logic [OP_W-1:0] af_d, bf_d, af_q, bf_q;
    logic            eff_sub_d, eff_sub_q;
    logic            a_ge_b_d, a_ge_b_q;
    logic            sign_a_q;
    logic            sb_d, sb_q;

    assign af_d      = {1'b1, mant_A, 3'b000};
    assign bf_d      = {~shift_flag, mant_B, GRS_in};
    assign eff_sub_d = sign_A ^ sign_B ^ sub;
    assign sb_d      = sign_B ^ sub;
    assign a_ge_b_d  = (af_d >= bf_d);

    // ------------------------------------------------------------------
    // Stage 2: add or ordered subtract
    // ------------------------------------------------------------------
    logic [MAG_W-1:0] mag_d, mag_q;
    logic             sign_d, sign_q;
    logic             z_d, z_q;

    always_comb begin
        mag_d  = '0;
        sign_d = sign_a_q;
        if (!eff_sub_q) begin
            mag_d = {1'b0, af_q} + {1'b0, bf_q};
        end else if (a_ge_b_q) begin
            mag_d = {1'b0, af_q - bf_q};
        end else begin
            mag_d  = {1'b0, bf_q - af_q};
            sign_d = sb_q;
        end
        z_d = (mag_d == '0);
        // An exact cancellation always produces +0.
        if (z_d) begin
            sign_d = 1'b0;
        end
    end

`ifdef ADDSUB_LZC_EN
    localparam int LZC_W = $clog2(MANT_W + 6);
    logic [LZC_W-1:0] lzc_d, lzc_q;

    // Scan upward so the highest set bit determines the count.
    always_comb begin
        lzc_d = LZC_W'(MAG_W);
        for (int i = 0; i < MAG_W; i++) begin
            if (mag_d[i]) begin
                lzc_d = LZC_W'(MAG_W - 1 - i);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            af_q       <= '0;
            bf_q       <= '0;
            eff_sub_q  <= 1'b0;
            a_ge_b_q   <= 1'b0;
            sign_a_q   <= 1'b0;
            sb_q       <= 1'b0;
            mag_q      <= '0;
            sign_q     <= 1'b0;
            z_q        <= 1'b0;
`ifdef ADDSUB_LZC_EN
            lzc_q      <= '0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_fire) begin
                af_q      <= af_d;
                bf_q      <= bf_d;
                eff_sub_q <= eff_sub_d;
                a_ge_b_q  <= a_ge_b_d;
                sign_a_q  <= sign_A;
                sb_q      <= sb_d;
            end
            if (s2_fire) begin
                mag_q  <= mag_d;
                sign_q <= sign_d;
                z_q    <= z_d;
`ifdef ADDSUB_LZC_EN
                lzc_q  <= lzc_d;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = s2_valid_q;
    assign sign      = sign_q;
    assign z_flag    = z_q;
    assign mant      = mag_q[MAG_W-1:3];
    assign GRS_out   = mag_q[2:0];
`ifdef ADDSUB_LZC_EN
    assign lzc       = lzc_q;
`endif

endmodule

// File: tb/tb_fp_mant_addsub_pipe.sv
// -----------------------------------------------------------------------------
// Bench for fp_mant_addsub_pipe (MANT_W = 23).
// It applies a table of hand-computed vectors one at a time and checks
// latency and results. It then runs a backpressure/drain sequence, an
// asynchronous mid-stream reset, and a post-reset idle check.
// -----------------------------------------------------------------------------
module tb_fp_mant_addsub_pipe;

    localparam int MANT_W = 23;
    localparam int NV     = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              sub;
    logic              shift_flag;
    logic              sign_A;
    logic [MANT_W-1:0] mant_A;
    logic              sign_B;
    logic [MANT_W-1:0] mant_B;
    logic [2:0]        GRS_in;
    logic              out_valid;
    logic              out_ready;
    logic              sign;
    logic              z_flag;
    logic [MANT_W+1:0] mant;
    logic [2:0]        GRS_out;
`ifdef ADDSUB_LZC_EN
    logic [$clog2(MANT_W+6)-1:0] lzc;
`endif

    always #5 clk = ~clk;

    fp_mant_addsub_pipe #(.MANT_W(MANT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .shift_flag(shift_flag),
        .sign_A    (sign_A),
        .mant_A    (mant_A),
        .sign_B    (sign_B),
        .mant_B    (mant_B),
        .GRS_in    (GRS_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .z_flag    (z_flag),
        .mant      (mant),
`ifdef ADDSUB_LZC_EN
        .lzc       (lzc),
`endif
        .GRS_out   (GRS_out)
    );

    typedef struct packed {
        logic              sub;
        logic              sf;
        logic              sa;
        logic [MANT_W-1:0] ma;
        logic              sb;
        logic [MANT_W-1:0] mb;
        logic [2:0]        grs;
        logic [MANT_W+1:0] e_mant;
        logic [2:0]        e_grs;
        logic              e_sign;
        logic              e_z;
    } vec_t;

    vec_t vecs [NV];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected leading-zero count, derived from the expected result fields.
    function automatic int lzc_ref(input logic [MANT_W+1:0] m, input logic [2:0] g);
        logic [MANT_W+4:0] v;
        int n;
        v = {m, g};
        n = MANT_W + 5;
        for (int i = MANT_W + 4; i >= 0; i--) begin
            if (v[i]) begin
                n = MANT_W + 4 - i;
                break;
            end
        end
        return n;
    endfunction

    task automatic drive(input int k);
        sub        = vecs[k].sub;
        shift_flag = vecs[k].sf;
        sign_A     = vecs[k].sa;
        mant_A     = vecs[k].ma;
        sign_B     = vecs[k].sb;
        mant_B     = vecs[k].mb;
        GRS_in     = vecs[k].grs;
    endtask

    task automatic check_result(input string tag, input int k);
        check({tag, "_mant"}, 64'(mant), 64'(vecs[k].e_mant));
        check({tag, "_grs"},  64'(GRS_out), 64'(vecs[k].e_grs));
        check({tag, "_sign"}, 64'(sign), 64'(vecs[k].e_sign));
        check({tag, "_z"},    64'(z_flag), 64'(vecs[k].e_z));
`ifdef ADDSUB_LZC_EN
        check({tag, "_lzc"},  64'(lzc), 64'(lzc_ref(vecs[k].e_mant, vecs[k].e_grs)));
`endif
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_mant"},      64'(mant), 64'd0);
        check({tag, "_grs"},       64'(GRS_out), 64'd0);
        check({tag, "_sign"},      64'(sign), 64'd0);
        check({tag, "_z"},         64'(z_flag), 64'd0);
`ifdef ADDSUB_LZC_EN
        check({tag, "_lzc"},       64'(lzc), 64'd0);
`endif
    endtask

    initial begin
        int  acc;
        int  rx;
        logic fire_in, fire_out;

        //           sub  sf   sa   mant_A      sb   mant_B      GRS     e_mant        e_grs   e_sign e_z
        vecs[0] = {1'b0, 1'b1, 1'b0, 23'h0A3D70, 1'b0, 23'h6B851E, 3'b000, 25'h0F5C28E, 3'b000, 1'b0, 1'b0};
        vecs[1] = {1'b1, 1'b1, 1'b0, 23'h0A3D70, 1'b0, 23'h6B851E, 3'b000, 25'h01EB852, 3'b000, 1'b0, 1'b0};
        vecs[2] = {1'b1, 1'b1, 1'b0, 23'h0A3D70, 1'b0, 23'h6B851E, 3'b101, 25'h01EB851, 3'b011, 1'b0, 1'b0};
        vecs[3] = {1'b1, 1'b0, 1'b0, 23'h000000, 1'b0, 23'h400000, 3'b000, 25'h0400000, 3'b000, 1'b1, 1'b0};
        vecs[4] = {1'b1, 1'b0, 1'b0, 23'h123456, 1'b0, 23'h123456, 3'b000, 25'h0000000, 3'b000, 1'b0, 1'b1};
        // Carry-out add of two negatives with full GRS.
        vecs[5] = {1'b0, 1'b0, 1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF, 3'b111, 25'h1FFFFFE, 3'b111, 1'b1, 1'b0};
        // Effective subtract from opposite signs; borrow runs all the way up.
        vecs[6] = {1'b0, 1'b1, 1'b0, 23'h000000, 1'b1, 23'h000000, 3'b001, 25'h07FFFFF, 3'b111, 1'b0, 1'b0};
        // Swap with sign taken from the effective B sign (sign_B ^ sub = 0).
        vecs[7] = {1'b1, 1'b0, 1'b1, 23'h000001, 1'b1, 23'h000002, 3'b000, 25'h0000001, 3'b000, 1'b0, 1'b0};
        // Negative A, effective subtract, no swap.
        vecs[8] = {1'b0, 1'b1, 1'b1, 23'h000000, 1'b0, 23'h000000, 3'b000, 25'h0800000, 3'b000, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(0);
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // ---- single transactions, latency and value checks ----
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive(k);
            in_valid = 1'b1;
            #1;
            check("vec_in_ready", 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            drive((k + 3) % NV);   // junk that must be ignored
            check("vec_latency1", 64'(out_valid), 64'd0);
            @(negedge clk);
            check("vec_out_valid", 64'(out_valid), 64'd1);
            check_result($sformatf("vec%0d", k), k);
            $display("[TB] vec %0d: mant=%h grs=%b sign=%b z=%b", k, mant, GRS_out, sign, z_flag);
            @(negedge clk);
            check("vec_drained", 64'(out_valid), 64'd0);
        end

        // ---- backpressure: out_ready low, stream vectors 0..3 ----
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (acc < 4) begin
                drive(acc);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                check_result("bp_hold", 0);
            end
            fire_in = in_valid & in_ready;
            @(posedge clk);
            if (fire_in) acc++;
        end
        @(negedge clk);
        #1;
        check("bp_accepts", 64'(acc), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check_result("bp_stable", 0);
        $display("[TB] backpressure: %0d accepted while stalled", acc);

        // ---- release: four results in order, one per cycle ----
        out_ready = 1'b1;
        rx = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (acc < 4) begin
                drive(acc);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            fire_in  = in_valid & in_ready;
            fire_out = out_valid & out_ready;
            if (c < 4) begin
                check("drain_every_cycle", 64'(fire_out), 64'd1);
            end
            if (fire_out) begin
                if (rx < 4) begin
                    check_result($sformatf("drain%0d", rx), rx);
                    $display("[TB] drain %0d: mant=%h grs=%b sign=%b", rx, mant, GRS_out, sign);
                end
                rx++;
            end
            @(posedge clk);
            if (fire_in) acc++;
        end
        check("drain_count", 64'(rx), 64'd4);

        // ---- asynchronous reset with both stages full ----
        @(negedge clk);
        out_ready = 1'b0;
        drive(5); in_valid = 1'b1;
        @(negedge clk);
        drive(6);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("prerst_out_valid", 64'(out_valid), 64'd1);
        check("prerst_in_ready", 64'(in_ready), 64'd0);
        check_result("prerst", 5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        $display("[TB] mid-stream reset applied");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("postrst_in_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("postrst_no_stale", 64'(out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_mant_addsub_pipe.md
Name: fp_mant_addsub_pipe

Overview:
- Pipelined, parametrised successor to the combinational mantissa adder/subtractor in the FP add/sub datapath.
- Takes the already-aligned operand mantissas (B pre-shifted, with its GRS bits) and the signs, and applies the effective operation.
- Produces result sign, magnitude mantissa with carry and hidden bit, GRS bits and a zero flag for the normaliser/rounder.
- Two register stages with valid/ready flow control on input and output; full throughput; generalised to any mantissa width.

Parameters:
- MANT_W, 23, stored mantissa width (23 single, 52 double, 10 half).
- GRS_W is fixed at 3 and is not a parameter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands this cycle.
- sub  in  1  1 = A-B, 0 = A+B.
- shift_flag  in  1  B was right-shifted for alignment; B hidden bit = ~shift_flag.
- sign_A  in  1  sign of A.
- mant_A  in  MANT_W  stored mantissa of A.
- sign_B  in  1  sign of B.
- mant_B  in  MANT_W  aligned mantissa of B.
- GRS_in  in  3  guard/round/sticky bits shifted out of B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sign  out  1  result sign.
- z_flag  out  1  result magnitude is exactly zero.
- mant  out  MANT_W+2  {carry, hidden, mantissa} of result magnitude.
- GRS_out  out  3  result guard/round/sticky bits.

Behaviour:
- Operand construction: Af = {1, mant_A, 000}; Bf = {~shift_flag, mant_B, GRS_in}. Both are MANT_W+4 bits, unsigned.
- Effective subtract: eff_sub = sign_A ^ sign_B ^ sub. Effective sign of B: sB = sign_B ^ sub.
- Stage 1, on an in_valid && in_ready cycle, registers:
  - Af and Bf.
  - eff_sub.
  - a_ge_b = (Af >= Bf).
  - sign_A and sB.
- Stage 2 computes a MANT_W+5 bit magnitude:
  - eff_sub = 0: mag = Af + Bf, sign = sign_A.
  - eff_sub = 1 and a_ge_b: mag = Af - Bf, sign = sign_A.
  - eff_sub = 1 and not a_ge_b: mag = Bf - Af, sign = sB.
  - mag == 0: z_flag = 1 and sign forced to 0 (+0).
- Output mapping: mant = mag[MANT_W+4:3], GRS_out = mag[2:0]. The subtraction is exact; no sticky re-OR is performed.
- The stage-2 result, sign and z_flag are registered; all outputs are driven from flops.
- Latency: out_valid rises 2 cycles after the accepting edge.
- Handshake:
  - A stage loads when it is empty or its content moves downstream in the same cycle.
  - in_ready = ~s1_valid | ~s2_valid | out_ready.
  - With out_ready held at 1, throughput is one result per cycle.
- Output hold: while out_valid=1 and out_ready=0, the output registers hold and all data outputs stay stable.
- Input handling: input data is ignored when in_valid=0 or in_ready=0.
- Full pipeline with out_ready=0: in_ready=0 and nothing is lost.
- Simultaneous accept and drain on a full pipe: allowed, and results stay in order.
- Reset (asynchronous, any time, including mid-operation):
  - Both stage valids clear and out_valid = 0.
  - sign = 0, z_flag = 0, mant = 0, GRS_out = 0.
  - in_ready = 1 while reset is deasserted.
  - In-flight results are discarded.

Optional Feature:
- Macro: ADDSUB_LZC_EN.
- When defined:
  - Adds output port lzc, width $clog2(MANT_W+6).
  - lzc is registered alongside the stage-2 result and follows the same valid/ready timing.
  - lzc = count of leading zeros of {mant, GRS_out}; value MANT_W+5 when the result is zero.
  - Reset value is 0.
- When undefined: the port and its logic are absent; everything else is identical.

Test Plan:
- Add, MANT_W=23, sub=0, shift_flag=1, sign_A=sign_B=0, mant_A=0x0A3D70, mant_B=0x6B851E, GRS_in=000 -> 2 cycles later: out_valid=1, mant=0x0F5C28E, GRS_out=000, sign=0, z_flag=0.
- Same operands with sub=1 -> mant=0x01EB852, GRS_out=000, sign=0; with ADDSUB_LZC_EN, lzc=4.
- Same operands with sub=1, GRS_in=101 -> mant=0x01EB851, GRS_out=011 (borrow propagates), sign=0.
- Swap and zero cases:
  - sub=1, shift_flag=0, signs 0, mant_A=0, mant_B=0x400000 -> mant=0x0400000, sign=1.
  - mant_A=mant_B=0x123456, shift_flag=0, sub=1 -> z_flag=1, sign=0, mant=0, GRS_out=000.
- Backpressure: stream 4 vectors with in_valid=1, hold out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts and out data stays stable; release -> all 4 results delivered in order, one per cycle.
- Reset mid-stream: assert rst_n=0 asynchronously with both stages full -> out_valid and all outputs 0 immediately; after release, in_ready=1 and no stale result appears.
